// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL field positions, mode codes and FSM state encodings.
package timer_device_pkg;

   // Base of the Timer window, shared with the bridge address decode.
   localparam logic [31:0] TIMER_BASE = 32'h0000_7f00;

   // Word offsets, as seen on addr[3:2].
   localparam logic [1:0] TIMER_CTRL   = 2'b00;
   localparam logic [1:0] TIMER_PRESET = 2'b01;
   localparam logic [1:0] TIMER_COUNT  = 2'b10;

   // CTRL bit positions.
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   // Mode codes; 2'b10 and 2'b11 are stored but behave as one-shot.
   localparam logic [1:0] ONESHOT = 2'b00;
   localparam logic [1:0] RELOAD  = 2'b01;

   // CTRL register image, laid out to match bits 3:0 of the register.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      CNT  = 2'b10,
      INT  = 2'b11
   } state_t;

   // Unpack the writable CTRL fields from a bus word.
   function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
      ctrl_t c;
      c.en   = w[CTRL_EN];
      c.mode = w[CTRL_MODE_HI:CTRL_MODE_LO];
      c.im   = w[CTRL_IM];
      return c;
   endfunction

endpackage

// File: rtl/timer_device.sv
// Programmable countdown timer in the bridge's Timer window. Three word
// registers (CTRL, PRESET, read-only COUNT), an IDLE/LOAD/CNT/INT state
// machine, and a maskable interrupt request toward CP0.
module timer_device
   import timer_device_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   ctrl_t       ctrl_q,     ctrl_d;
   logic [31:0] preset_q,   preset_d;
   logic [31:0] count_q,    count_d;
   state_t      state_q,    state_d;
   logic        irq_flag_q, irq_flag_d;

   logic [1:0]  reg_sel;
   logic        is_reload;

   // Only addr[3:2] selects a register; the bridge has already decoded the rest.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

   assign reg_sel   = addr[3:2];
   assign is_reload = (ctrl_q.mode == RELOAD);

   // Next-state logic: FSM update first, then CPU writes so that a CTRL
   // write wins over any same-edge FSM change to En or the flag.
   always_comb begin
      // NOTE: every *_d gets its hold value first, so no path through this
      // block leaves a signal unassigned and no latch is inferred.
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      state_d    = state_q;
      irq_flag_d = irq_flag_q;

      unique case (state_q)
         IDLE: begin
            if (ctrl_q.en) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!ctrl_q.en) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               // PRESET of 0 or 1 both land here; COUNT never goes below 0.
               count_d    = '0;
               irq_flag_d = 1'b1;
               state_d    = INT;
            end
         end
         INT: begin
            state_d = IDLE;
            if (is_reload) irq_flag_d = 1'b0;
            else           ctrl_d.en  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (we) begin
         unique case (reg_sel)
            TIMER_CTRL: begin
               ctrl_d     = ctrl_from_word(wdata);
               irq_flag_d = 1'b0;
            end
            TIMER_PRESET: preset_d = wdata;
            default: ;  // COUNT and offset 0xc are not writable
         endcase
      end
   end

   // Register update with synchronous, active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         irq_flag_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         state_q    <= state_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // Combinational read mux; the bridge registers the result.
   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         TIMER_CTRL:   rdata = {28'b0, ctrl_q};
         TIMER_PRESET: rdata = preset_q;
         TIMER_COUNT:  rdata = count_q;
         default:      rdata = '0;
      endcase
   end

   // The mask gates the request only; the flag itself is left untouched.
   assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device. Inputs change 1 time unit
// after the rising edge; outputs are sampled at least 1 unit after it.
module tb_timer_device;

   localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
   localparam logic [31:0] A_PRESET = 32'h0000_7f04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7f08;
   localparam logic [31:0] A_RSVD   = 32'h0000_7f0c;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = A_CTRL;
   logic        we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   timer_device dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to 1 unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus write landing on the next edge; returns just after that edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   // Combinational read within the current cycle.
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [31:0] v;
   logic        irq_seen;

   initial begin
      // ---------------- reset ----------------
      reset = 1'b1;
      idle_cycles(2);
      reset = 1'b0;
      rd(A_CTRL,   v); check("rst_ctrl",   v, 32'h0);
      rd(A_PRESET, v); check("rst_preset", v, 32'h0);
      rd(A_COUNT,  v); check("rst_count",  v, 32'h0);
      rd(A_RSVD,   v); check("rst_rsvd",   v, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);

      // ---------------- one-shot, PRESET=5 ----------------
      wr(A_PRESET, 32'd5);
      wr(A_CTRL, 32'h9);            // edge 0
      rd(A_CTRL, v); check("os_ctrl_rb", v, 32'h9);
      idle_cycles(2);               // after edge 2
      for (int k = 5; k >= 1; k--) begin
         rd(A_COUNT, v);
         check($sformatf("os_count_%0d", k), v, 32'(k));
         check($sformatf("os_irq_low_%0d", k), {31'b0, irq}, 32'h0);
         tick();
      end
      // now after edge 7
      check("os_irq_edge7", {31'b0, irq}, 32'h1);
      rd(A_COUNT, v); check("os_count_zero", v, 32'h0);
      tick();                       // after edge 8: back in IDLE, En cleared
      rd(A_CTRL, v); check("os_ctrl_en_cleared", v, 32'h8);
      idle_cycles(3);
      check("os_irq_held", {31'b0, irq}, 32'h1);
      rd(A_COUNT, v); check("os_count_stays0", v, 32'h0);
      wr(A_CTRL, 32'h0);
      check("os_irq_cleared", {31'b0, irq}, 32'h0);

      // ---------------- auto-reload, PRESET=3 ----------------
      wr(A_PRESET, 32'd3);
      wr(A_CTRL, 32'hB);            // edge 0
      for (int e = 1; e <= 18; e++) begin
         tick();
         check($sformatf("ar_irq_e%0d", e), {31'b0, irq},
               (e == 5 || e == 11 || e == 17) ? 32'h1 : 32'h0);
         if (e == 2 || e == 8 || e == 14) begin
            rd(A_COUNT, v);
            check($sformatf("ar_count_e%0d", e), v, 32'd3);
         end
      end
      rd(A_CTRL, v); check("ar_ctrl_en_kept", v, 32'hB);
      wr(A_CTRL, 32'h0);
      idle_cycles(4);

      // ---------------- masked, PRESET=0 ----------------
      wr(A_PRESET, 32'd0);
      wr(A_CTRL, 32'h1);            // edge 0, IM=0
      idle_cycles(2);
      check("mk_flag_e2", {31'b0, dut.irq_flag_q}, 32'h0);
      tick();
      check("mk_flag_e3", {31'b0, dut.irq_flag_q}, 32'h1);
      check("mk_irq_masked", {31'b0, irq}, 32'h0);
      idle_cycles(2);
      check("mk_flag_held", {31'b0, dut.irq_flag_q}, 32'h1);
      wr(A_CTRL, 32'h8);
      check("mk_flag_cleared", {31'b0, dut.irq_flag_q}, 32'h0);
      check("mk_irq_after_unmask", {31'b0, irq}, 32'h0);
      tick();
      check("mk_irq_stays0", {31'b0, irq}, 32'h0);

      // ------- mode 10 behaves as one-shot; upper CTRL bits not stored -------
      wr(A_PRESET, 32'd1);
      wr(A_CTRL, 32'hD);            // En, mode 10, IM
      rd(A_CTRL, v); check("m2_ctrl_rb", v, 32'hD);
      idle_cycles(3);
      check("m2_irq_e3", {31'b0, irq}, 32'h1);
      tick();
      rd(A_CTRL, v); check("m2_en_cleared", v, 32'hC);
      wr(A_CTRL, 32'hFFFF_FFF0);
      rd(A_CTRL, v); check("ctrl_upper_bits", v, 32'h0);
      check("m2_irq_cleared", {31'b0, irq}, 32'h0);

      // ---------------- mid-count stop and restart ----------------
      wr(A_PRESET, 32'd10);
      wr(A_CTRL, 32'h9);            // edge 0
      idle_cycles(5);               // after edge 5: COUNT=7
      rd(A_COUNT, v); check("mc_count7", v, 32'd7);
      wr(A_CTRL, 32'h8);            // edge 6: COUNT becomes 6, En=0
      rd(A_COUNT, v); check("mc_count6", v, 32'd6);
      idle_cycles(4);
      rd(A_COUNT, v); check("mc_frozen", v, 32'd6);
      check("mc_irq0", {31'b0, irq}, 32'h0);
      wr(A_COUNT, 32'h1234);
      rd(A_COUNT, v); check("mc_count_ro", v, 32'd6);
      wr(A_RSVD, 32'hDEAD_BEEF);
      rd(A_RSVD, v); check("mc_rsvd_ro", v, 32'h0);
      rd(A_PRESET, v); check("mc_preset_kept", v, 32'd10);
      wr(A_PRESET, 32'd2);
      wr(A_CTRL, 32'h9);            // edge 0
      idle_cycles(2);
      rd(A_COUNT, v); check("mc_reload2", v, 32'd2);
      tick();
      check("mc_irq_e3", {31'b0, irq}, 32'h0);
      tick();
      check("mc_irq_e4", {31'b0, irq}, 32'h1);
      wr(A_CTRL, 32'h0);
      idle_cycles(2);

      // ---------------- PRESET write during CNT, then reset ----------------
      wr(A_PRESET, 32'd6);
      wr(A_CTRL, 32'hB);            // edge 0
      idle_cycles(2);               // after edge 2: COUNT=6
      wr(A_PRESET, 32'd9);          // edge 3
      rd(A_COUNT, v); check("rs_preset_no_effect", v, 32'd5);
      tick();                       // after edge 4
      rd(A_COUNT, v); check("rs_count4", v, 32'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd(A_CTRL,   v); check("rs_ctrl0",   v, 32'h0);
      rd(A_PRESET, v); check("rs_preset0", v, 32'h0);
      rd(A_COUNT,  v); check("rs_count0",  v, 32'h0);
      check("rs_irq0", {31'b0, irq}, 32'h0);
      irq_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         irq_seen |= irq;
      end
      check("rs_no_irq_after", {31'b0, irq_seen}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
